// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multicycle register/memory CPU with a valid/ready instruction handshake.
//
// One instruction is accepted in IDLE. It is then executed through EXEC and, if needed,
// MEM and WB. Data memory is internal to the core.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active low
//   instruction   instruction word {op, x1, x2, x3, spare, imm}
//   instr_valid   instruction presented
//   instr_ready   core can accept an instruction (IDLE only)
//   done          one-cycle pulse when an instruction retires
//   halted        high while in HALT
//   zero_flag     last ALU result was zero
//   carry_flag    carry (ADD/ADDI) or borrow (SUB) of the last arithmetic op
//   dbg_reg_sel   debug register index
//   dbg_reg_data  regfile[dbg_reg_sel], combinational
//   dbg_mem_addr  debug memory address
//   dbg_mem_data  dmem[dbg_mem_addr], combinational

module multicycle_cpu #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned ADDR_BITS   = 5,   // must not exceed DATA_WIDTH
   parameter int unsigned REG_BITS    = 2,
   parameter int unsigned INSTR_WIDTH = 20   // >= 3 + 3*REG_BITS + DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INSTR_WIDTH-1:0] instruction,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   output logic                   done,
   output logic                   halted,
   output logic                   zero_flag,
   output logic                   carry_flag,
   input  logic [REG_BITS-1:0]    dbg_reg_sel,
   output logic [DATA_WIDTH-1:0]  dbg_reg_data,
   input  logic [ADDR_BITS-1:0]   dbg_mem_addr,
   output logic [DATA_WIDTH-1:0]  dbg_mem_data
);

   localparam int NumRegs  = 2 ** REG_BITS;
   localparam int MemDepth = 2 ** ADDR_BITS;
   localparam int unsigned UsedBits = 3 + 3 * REG_BITS + DATA_WIDTH;

   localparam logic [2:0] OpAdd   = 3'b000;
   localparam logic [2:0] OpSub   = 3'b001;
   localparam logic [2:0] OpAnd   = 3'b010;
   localparam logic [2:0] OpOr    = 3'b011;
   localparam logic [2:0] OpAddi  = 3'b100;
   localparam logic [2:0] OpLoad  = 3'b101;
   localparam logic [2:0] OpStore = 3'b110;
   localparam logic [2:0] OpHalt  = 3'b111;

   typedef enum logic [2:0] {StIdle, StExec, StMem, StWb, StHalt} state_e;

   state_e                   state_q;
   logic [INSTR_WIDTH-1:0]   instr_q;
   logic [DATA_WIDTH-1:0]    result_q;
   logic [ADDR_BITS-1:0]     addr_q;
   logic                     zero_q;
   logic                     carry_q;
   logic                     done_q;
   logic                     halted_q;
   logic                     ready_q;
   logic [DATA_WIDTH-1:0]    regfile_q [NumRegs];
   logic [DATA_WIDTH-1:0]    dmem_q    [MemDepth];

   // Fields of the latched instruction; the live input is ignored once accepted.
   logic [2:0]               op;
   logic [REG_BITS-1:0]      x1;
   logic [REG_BITS-1:0]      x2;
   logic [REG_BITS-1:0]      x3;
   logic [DATA_WIDTH-1:0]    imm;

   assign op  = instr_q[INSTR_WIDTH-1 -: 3];
   assign x1  = instr_q[INSTR_WIDTH-4 -: REG_BITS];
   assign x2  = instr_q[INSTR_WIDTH-4-REG_BITS -: REG_BITS];
   assign x3  = instr_q[INSTR_WIDTH-4-2*REG_BITS -: REG_BITS];
   assign imm = instr_q[DATA_WIDTH-1:0];

   if (INSTR_WIDTH > UsedBits) begin : g_spare
      logic unused_spare;
      assign unused_spare = ^instr_q[INSTR_WIDTH-4-3*REG_BITS : DATA_WIDTH];
   end

   // Operands are read in EXEC, after any preceding WB, so no forwarding is needed.
   logic [DATA_WIDTH-1:0]    opa;
   logic [DATA_WIDTH-1:0]    opb;
   logic [DATA_WIDTH:0]      sum_w;
   logic [DATA_WIDTH:0]      diff_w;
   logic [DATA_WIDTH-1:0]    alu_res;
   logic                     alu_carry;
   logic [DATA_WIDTH-1:0]    addr_sum;
   logic [ADDR_BITS-1:0]     mem_addr;

   always_comb begin
      opa       = regfile_q[x2];
      opb       = (op == OpAddi) ? imm : regfile_q[x3];
      sum_w     = {1'b0, opa} + {1'b0, opb};
      // Top bit of the widened difference is the borrow.
      diff_w    = {1'b0, opa} - {1'b0, opb};
      alu_res   = '0;
      alu_carry = 1'b0;
      unique case (op)
         OpAdd, OpAddi: begin
            alu_res   = sum_w[DATA_WIDTH-1:0];
            alu_carry = sum_w[DATA_WIDTH];
         end
         OpSub: begin
            alu_res   = diff_w[DATA_WIDTH-1:0];
            alu_carry = diff_w[DATA_WIDTH];
         end
         OpAnd:   alu_res = opa & opb;
         OpOr:    alu_res = opa | opb;
         default: begin
            alu_res   = '0;
            alu_carry = 1'b0;
         end
      endcase
      // Effective address wraps within the memory depth.
      addr_sum = opa + imm;
      mem_addr = addr_sum[ADDR_BITS-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         instr_q  <= '0;
         result_q <= '0;
         addr_q   <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         done_q   <= 1'b0;
         halted_q <= 1'b0;
         ready_q  <= 1'b1;
         for (int i = 0; i < NumRegs; i++) begin
            regfile_q[i] <= DATA_WIDTH'(i);
         end
         for (int i = 0; i < MemDepth; i++) begin
            dmem_q[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (instr_valid) begin
                  instr_q <= instruction;
                  ready_q <= 1'b0;
                  state_q <= StExec;
               end
            end
            StExec: begin
               if (op == OpLoad || op == OpStore) begin
                  addr_q   <= mem_addr;
                  result_q <= regfile_q[x1];  // store data
                  state_q  <= StMem;
               end else if (op == OpHalt) begin
                  halted_q <= 1'b1;
                  done_q   <= 1'b1;
                  state_q  <= StHalt;
               end else begin
                  result_q <= alu_res;
                  zero_q   <= (alu_res == '0);
                  carry_q  <= alu_carry;
                  state_q  <= StWb;
               end
            end
            StMem: begin
               if (op == OpStore) begin
                  dmem_q[addr_q] <= result_q;
                  done_q         <= 1'b1;
                  ready_q        <= 1'b1;
                  state_q        <= StIdle;
               end else begin
                  result_q <= dmem_q[addr_q];
                  state_q  <= StWb;
               end
            end
            StWb: begin
               regfile_q[x1] <= result_q;
               done_q        <= 1'b1;
               ready_q       <= 1'b1;
               state_q       <= StIdle;
            end
            StHalt: begin
               state_q <= StHalt;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign instr_ready  = ready_q;
   assign done         = done_q;
   assign halted       = halted_q;
   assign zero_flag    = zero_q;
   assign carry_flag   = carry_q;
   assign dbg_reg_data = regfile_q[dbg_reg_sel];
   assign dbg_mem_data = dmem_q[dbg_mem_addr];

endmodule
